// File: rtl/prod_accum_if.sv
// Handshake bundle between a mul4bit producer, prod_accum and its result consumer.
interface prod_accum_if #(
    parameter int unsigned ACC_W = 16
);
    logic [7:0]       p_in;
    logic             p_valid;
    logic             p_ready;
    logic             clear;
    logic [ACC_W-1:0] acc_out;
    logic             acc_valid;
    logic             acc_ready;
    logic [7:0]       count;
    logic             ovf;

    modport master (
        output p_in, p_valid, clear, acc_ready,
        input  p_ready, acc_out, acc_valid, count, ovf
    );

    modport slave (
        input  p_in, p_valid, clear, acc_ready,
        output p_ready, acc_out, acc_valid, count, ovf
    );
endinterface

// File: rtl/prod_accum.sv
// Accumulates N unsigned 8-bit products into one ACC_W-bit frame result.
// Optional PROD_ACCUM_SAT_EN: saturate the sum at all-ones instead of wrapping.
module prod_accum #(
    parameter int unsigned ACC_W = 16,
    parameter int unsigned N     = 4
) (
    input  logic         clk,
    input  logic         rst,
    prod_accum_if.slave  bus
);
    localparam logic [0:0]  ACCUM = 1'b0;
    localparam logic [0:0]  HOLD  = 1'b1;
    localparam int unsigned SUM_W = ACC_W + 1;
    localparam logic [7:0]  LAST  = 8'(N - 1);

    logic [0:0]       state, state_d;
    logic [ACC_W-1:0] acc, acc_d;
    logic [7:0]       cnt, cnt_d;
    logic             ovf_q, ovf_d;
    logic [SUM_W-1:0] sum_c;
    logic             carry_c;
    logic             p_ready_c;

    // Ready never depends on p_valid, only on registered state and clear.
    assign p_ready_c = (state == ACCUM) && !bus.clear;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_d;
            acc   <= acc_d;
            cnt   <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Next state: clear beats release, release beats transfer.
    always_comb begin
        state_d = state;
        acc_d   = acc;
        cnt_d   = cnt;
        ovf_d   = ovf_q;
        sum_c   = {1'b0, acc} + SUM_W'(bus.p_in);
        carry_c = sum_c[ACC_W];

        if (bus.clear) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (state == HOLD) begin
            if (bus.acc_ready) begin
                state_d = ACCUM;
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
            end
        end else if (bus.p_valid && p_ready_c) begin
`ifdef PROD_ACCUM_SAT_EN
            acc_d = carry_c ? '1 : sum_c[ACC_W-1:0];
`else
            acc_d = sum_c[ACC_W-1:0];
`endif
            cnt_d = cnt + 8'd1;
            ovf_d = ovf_q | carry_c;
            if (cnt == LAST) begin
                state_d = HOLD;
            end
        end
    end

    assign bus.p_ready   = p_ready_c;
    assign bus.acc_valid = (state == HOLD);
    assign bus.acc_out   = acc;
    assign bus.count     = cnt;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_prod_accum.sv
// Self-checking bench: 16-bit and 8-bit accumulators share one stimulus stream.
module tb_prod_accum;
    localparam int unsigned NP = 4;

    logic       clk;
    logic       rst;
    logic [7:0] p_in;
    logic       p_valid;
    logic       clear;
    logic       acc_ready;
    bit         chk_en;

    int n_checks;
    int n_errors;

    // Model: per-DUT frame contents as an unbounded sum plus a "result pending" flag.
    int m_sum  [2];
    int m_n    [2];
    bit m_done [2];

    prod_accum_if #(.ACC_W(16)) bus16 ();
    prod_accum_if #(.ACC_W(8))  bus8  ();

    assign bus16.p_in      = p_in;
    assign bus16.p_valid   = p_valid;
    assign bus16.clear     = clear;
    assign bus16.acc_ready = acc_ready;
    assign bus8.p_in       = p_in;
    assign bus8.p_valid    = p_valid;
    assign bus8.clear      = clear;
    assign bus8.acc_ready  = acc_ready;

    prod_accum #(.ACC_W(16), .N(NP)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    prod_accum #(.ACC_W(8),  .N(NP)) dut8  (.clk(clk), .rst(rst), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint exp_acc(input int i);
        longint mx;
        mx = (i == 0) ? 64'd65535 : 64'd255;
`ifdef PROD_ACCUM_SAT_EN
        return (longint'(m_sum[i]) > mx) ? mx : longint'(m_sum[i]);
`else
        return longint'(m_sum[i]) % (mx + 1);
`endif
    endfunction

    function automatic longint exp_ovf(input int i);
        longint mx;
        mx = (i == 0) ? 64'd65535 : 64'd255;
        return (longint'(m_sum[i]) > mx) ? 64'd1 : 64'd0;
    endfunction

    // Reference update from the sampled inputs at each rising edge.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst || clear || (m_done[i] && acc_ready)) begin
                m_sum[i]  <= 0;
                m_n[i]    <= 0;
                m_done[i] <= 1'b0;
            end else if (!m_done[i] && p_valid) begin
                m_sum[i]  <= m_sum[i] + int'(p_in);
                m_n[i]    <= m_n[i] + 1;
                m_done[i] <= (m_n[i] + 1 == int'(NP));
            end
        end
    end

    task automatic cmp(input string nm, input int i, input logic pr, input longint acc,
                       input logic av, input longint cnt, input logic ov);
        chk({nm, ".p_ready"},   longint'(pr), longint'(!m_done[i] && !clear));
        chk({nm, ".acc_out"},   acc,          exp_acc(i));
        chk({nm, ".acc_valid"}, longint'(av), longint'(m_done[i]));
        chk({nm, ".count"},     cnt,          longint'(m_n[i]));
        chk({nm, ".ovf"},       longint'(ov), exp_ovf(i));
    endtask

    // Mid-cycle compare of both DUTs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("d16", 0, bus16.p_ready, longint'(bus16.acc_out), bus16.acc_valid,
                longint'(bus16.count), bus16.ovf);
            cmp("d8", 1, bus8.p_ready, longint'(bus8.acc_out), bus8.acc_valid,
                longint'(bus8.count), bus8.ovf);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
        logic [7:0] v [4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int k = 0; k < 4; k++) begin
            p_valid = 1'b1;
            p_in    = v[k];
            cyc();
        end
        p_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] bv [4];
        n_checks  = 0;
        n_errors  = 0;
        chk_en    = 1'b0;
        rst       = 1'b1;
        p_in      = '0;
        p_valid   = 1'b0;
        clear     = 1'b0;
        acc_ready = 1'b1;
        repeat (2) cyc();
        rst    = 1'b0;
        chk_en = 1'b1;
        chk("reset.p_ready", longint'(bus16.p_ready), 1);
        chk("reset.acc_out", longint'(bus16.acc_out), 0);
        chk("reset.acc_valid", longint'(bus16.acc_valid), 0);
        chk("reset.ovf", longint'(bus16.ovf), 0);

        // Basic frame
        send_frame(8'd30, 8'd0, 8'd168, 8'd99);
        chk("t1.acc_out", longint'(bus16.acc_out), 297);
        chk("t1.acc_valid", longint'(bus16.acc_valid), 1);
        chk("t1.count", longint'(bus16.count), 4);
        chk("t1.p_ready", longint'(bus16.p_ready), 0);
        cyc();
        chk("t1.rel_acc", longint'(bus16.acc_out), 0);
        chk("t1.rel_count", longint'(bus16.count), 0);
        chk("t1.rel_ready", longint'(bus16.p_ready), 1);

        // Backpressure
        acc_ready = 1'b0;
        send_frame(8'd30, 8'd0, 8'd168, 8'd99);
        p_valid = 1'b1;
        p_in    = 8'd81;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("t2.hold_acc", longint'(bus16.acc_out), 297);
            chk("t2.hold_count", longint'(bus16.count), 4);
        end
        acc_ready = 1'b1;
        cyc();
        chk("t2.rel_ready", longint'(bus16.p_ready), 1);
        cyc();
        chk("t2.acc81", longint'(bus16.acc_out), 81);
        p_valid = 1'b0;
        clear   = 1'b1;
        cyc();
        clear = 1'b0;

        // Bubbles
        bv[0] = 8'd25; bv[1] = 8'd81; bv[2] = 8'd0; bv[3] = 8'd144;
        for (int k = 0; k < 4; k++) begin
            p_valid = 1'b1;
            p_in    = bv[k];
            cyc();
            p_valid = 1'b0;
            chk("t3.count", longint'(bus16.count), k + 1);
            chk("t3.acc_valid", longint'(bus16.acc_valid), (k == 3) ? 1 : 0);
            if (k == 3) chk("t3.acc_out", longint'(bus16.acc_out), 250);
            for (int g = 0; g < 2; g++) begin
                cyc();
                if (k < 3) chk("t3.bubble_count", longint'(bus16.count), k + 1);
            end
        end

        // Clear
        p_valid = 1'b1; p_in = 8'd30;  cyc();
        p_in = 8'd168; cyc();
        p_valid = 1'b0;
        clear   = 1'b1;
        #1;
        chk("t4.clr_ready", longint'(bus16.p_ready), 0);
        cyc();
        chk("t4.clr_acc", longint'(bus16.acc_out), 0);
        chk("t4.clr_count", longint'(bus16.count), 0);
        p_valid = 1'b1;
        p_in    = 8'd99;
        #1;
        chk("t4.clr_pv_ready", longint'(bus16.p_ready), 0);
        cyc();
        chk("t4.clr_pv_count", longint'(bus16.count), 0);
        clear   = 1'b0;
        p_valid = 1'b0;

        // Overflow on the 8-bit accumulator
        p_valid = 1'b1; p_in = 8'd225; cyc();
        cyc();
        p_valid = 1'b0;
`ifdef PROD_ACCUM_SAT_EN
        chk("t5.acc8", longint'(bus8.acc_out), 255);
`else
        chk("t5.acc8", longint'(bus8.acc_out), 194);
`endif
        chk("t5.ovf8", longint'(bus8.ovf), 1);
        chk("t5.acc16", longint'(bus16.acc_out), 450);
        chk("t5.ovf16", longint'(bus16.ovf), 0);
        p_valid = 1'b1; p_in = 8'd0; cyc();
        cyc();
        p_valid = 1'b0;
        chk("t5.hold_ovf8", longint'(bus8.ovf), 1);
        cyc();
        chk("t5.rel_ovf8", longint'(bus8.ovf), 0);

        // Reset in HOLD
        acc_ready = 1'b0;
        send_frame(8'd30, 8'd0, 8'd168, 8'd99);
        chk("t6.pre_acc", longint'(bus16.acc_out), 297);
        rst = 1'b1;
        cyc();
        chk("t6.acc_valid", longint'(bus16.acc_valid), 0);
        chk("t6.acc_out", longint'(bus16.acc_out), 0);
        chk("t6.count", longint'(bus16.count), 0);
        chk("t6.ovf", longint'(bus16.ovf), 0);
        rst       = 1'b0;
        acc_ready = 1'b1;
        #1;
        chk("t6.p_ready", longint'(bus16.p_ready), 1);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            #1;
            p_valid   = ($urandom_range(0, 9) < 7);
            p_in      = ($urandom_range(0, 3) == 0) ? 8'd225 : 8'($urandom_range(0, 255));
            acc_ready = ($urandom_range(0, 9) < 6);
            clear     = ($urandom_range(0, 99) < 3);
            rst       = ($urandom_range(0, 199) == 0);
        end
        cyc();
        rst   = 1'b0;
        clear = 1'b0;
        cyc();
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
